// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction fetch (0)
// and the load/store unit (1), with per-transaction timeout abort.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  // TIMEOUT of zero disables the abort; otherwise err fires in the TIMEOUT-th wait cycle.
  localparam logic       TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       busy_s;
  logic       ack_s;
  logic       err_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      tcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    tcnt_d     = tcnt_q;
    busy_s     = 1'b0;
    ack_s      = 1'b0;
    err_s      = 1'b0;
    case (state_q)
      IDLE: begin
        tcnt_d = 8'd0;
        if (req0 && req1) begin
          // Contention: the requester that did not win last time goes first.
          sel_d      = ~last_gnt_q;
          last_gnt_d = ~last_gnt_q;
          state_d    = last_gnt_q ? BUSY0 : BUSY1;
        end else if (req0) begin
          sel_d      = 1'b0;
          last_gnt_d = 1'b0;
          state_d    = BUSY0;
        end else if (req1) begin
          sel_d      = 1'b1;
          last_gnt_d = 1'b1;
          state_d    = BUSY1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY0, BUSY1: begin
        busy_s = 1'b1;
        if (mem_ack) begin
          ack_s   = 1'b1;
          state_d = IDLE;
          tcnt_d  = 8'd0;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          err_s   = 1'b1;
          state_d = IDLE;
          tcnt_d  = 8'd0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  assign gnt0    = (state_q == BUSY0);
  assign gnt1    = (state_q == BUSY1);
  assign mem_req = busy_s;

  // Port muxes are forced to zero while idle so nothing leaks before the first grant.
  assign mem_addr  = busy_s ? (sel_q ? addr1  : addr0)  : 32'd0;
  assign mem_wdata = busy_s ? (sel_q ? wdata1 : wdata0) : 32'd0;
  assign mem_we    = busy_s ? (sel_q ? we1    : we0)    : 1'b0;

  assign ack0  = ack_s & ~sel_q;
  assign ack1  = ack_s &  sel_q;
  assign err0  = err_s & ~sel_q;
  assign err1  = err_s &  sel_q;
  assign rdata = ack_s ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model. A second instance with TIMEOUT=0 covers the disabled timeout.
module tb_mem_port_arbiter;

  localparam int T_MAIN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, mem_ack;
  logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

  logic        gnt0, gnt1, ack0, ack1, err0, err1, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;

  logic        n_gnt0, n_gnt1, n_ack0, n_ack1, n_err0, n_err1, n_mem_req, n_mem_we;
  logic [31:0] n_rdata, n_mem_addr, n_mem_wdata;

  logic [6:0]  st;
  assign st = {gnt0, gnt1, mem_req, ack0, ack1, err0, err1};

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(T_MAIN)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .gnt0(n_gnt0), .gnt1(n_gnt1), .ack0(n_ack0), .ack1(n_ack1), .err0(n_err0), .err1(n_err1),
    .rdata(n_rdata), .mem_req(n_mem_req), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_we(n_mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_ack = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0; mem_rdata = 32'd0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; mem_ack = 1'b1; we0 = 1'b1;
    addr0 = 32'hFFFF_0000; wdata0 = 32'h1357_9BDF; mem_rdata = 32'h0F0F_0F0F;
    tick();
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL reset_status: got %b want %b", st, 7'b0); end
    n_vec++; if ({mem_addr, mem_wdata, rdata} !== 96'd0 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL reset_datapath: got addr %h wdata %h rdata %h we %b want zeros", mem_addr, mem_wdata, rdata, mem_we);
    end
    tick();
    clear_inputs();
    rst = 1'b0;
    #2;
    n_vec++; if (st !== 7'b0 || mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_release_idle: got %b/%h want 0/0", st, mem_addr); end
    tick();
  endtask

  task automatic test_single_read();
    logic [6:0] exp;
    req0 = 1'b1; addr0 = 32'h0000_1000; we0 = 1'b0; wdata0 = 32'h5555_AAAA;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL read_arb_cycle: got %b want %b", st, 7'b0); end
    tick();
    for (int b = 1; b <= 3; b++) begin
      mem_ack   = (b == 3);
      mem_rdata = (b == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #2;
      exp = {1'b1, 1'b0, 1'b1, (b == 3), 3'b000};
      n_vec++; if (st !== exp) begin n_err++; $display("FAIL read_busy%0d_status: got %b want %b", b, st, exp); end
      n_vec++; if (mem_addr !== 32'h0000_1000 || mem_we !== 1'b0) begin
        n_err++; $display("FAIL read_busy%0d_port: got %h/%b want 00001000/0", b, mem_addr, mem_we);
      end
      if (b == 3) begin
        n_vec++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_rdata: got %h want deadbeef", rdata); end
      end
      tick();
    end
    req0 = 1'b0; mem_ack = 1'b0;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL read_back_idle: got %b want %b", st, 7'b0); end
    tick();
  endtask

  task automatic test_write_steering();
    req0 = 1'b1; addr0 = 32'h0000_1000; wdata0 = 32'hAAAA_AAAA; we0 = 1'b0;
    req1 = 1'b1; addr1 = 32'h0000_2004; wdata1 = 32'h1234_5678; we1 = 1'b1;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL write_arb_cycle: got %b want %b", st, 7'b0); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0;
    #2;
    n_vec++; if (st !== 7'b0110100) begin n_err++; $display("FAIL write_status: got %b want %b", st, 7'b0110100); end
    n_vec++; if (mem_addr !== 32'h0000_2004 || mem_wdata !== 32'h1234_5678 || mem_we !== 1'b1) begin
      n_err++; $display("FAIL write_port: got %h/%h/%b want 00002004/12345678/1", mem_addr, mem_wdata, mem_we);
    end
    tick();
    clear_inputs();
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL write_back_idle: got %b want %b", st, 7'b0); end
    tick();
  endtask

  task automatic test_contention();
    logic [6:0] exp;
    int k;
    req0 = 1'b1; addr0 = $urandom; wdata0 = $urandom; we0 = 1'b0;
    req1 = 1'b1; addr1 = $urandom; wdata1 = $urandom; we1 = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0000;
    for (int t = 0; t < 6; t++) begin
      #2;
      n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL contend_idle%0d: got %b want %b", t, st, 7'b0); end
      tick();
      k = t % 2;
      #2;
      exp = {(k == 0), (k == 1), 1'b1, (k == 0), (k == 1), 2'b00};
      n_vec++; if (st !== exp) begin n_err++; $display("FAIL contend_grant%0d: got %b want %b", t, st, exp); end
      n_vec++; if (mem_addr !== (k == 1 ? addr1 : addr0) || mem_wdata !== (k == 1 ? wdata1 : wdata0)) begin
        n_err++; $display("FAIL contend_port%0d: got %h/%h want %h/%h", t, mem_addr, mem_wdata,
                          (k == 1 ? addr1 : addr0), (k == 1 ? wdata1 : wdata0));
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    req0 = 1'b1; addr0 = 32'h0000_3000; req1 = 1'b1; addr1 = 32'h0000_4000;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL timeout_arb: got %b want %b", st, 7'b0); end
    tick();
    for (int b = 1; b <= T_MAIN; b++) begin
      #2;
      exp = {1'b1, 1'b0, 1'b1, 2'b00, (b == T_MAIN), 1'b0};
      n_vec++; if (st !== exp) begin n_err++; $display("FAIL timeout_busy%0d: got %b want %b", b, st, exp); end
      tick();
    end
    req0 = 1'b0;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL timeout_back_idle: got %b want %b", st, 7'b0); end
    tick();
    mem_ack = 1'b1;
    #2;
    n_vec++; if (st !== 7'b0110100 || mem_addr !== 32'h0000_4000) begin
      n_err++; $display("FAIL timeout_next_req1: got %b/%h want %b/00004000", st, mem_addr, 7'b0110100);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_boundary();
    logic [6:0] exp;
    req0 = 1'b1; addr0 = 32'h0000_5000;
    tick();
    for (int b = 1; b <= T_MAIN; b++) begin
      mem_ack = (b == T_MAIN); mem_rdata = 32'h7777_0001;
      #2;
      exp = {1'b1, 1'b0, 1'b1, (b == T_MAIN), 3'b000};
      n_vec++; if (st !== exp) begin n_err++; $display("FAIL ack_vs_timeout%0d: got %b want %b", b, st, exp); end
      tick();
    end
    clear_inputs();
    mem_ack = 1'b1; mem_rdata = $urandom;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL stray_ack: got %b want %b", st, 7'b0); end
    tick();
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL stray_ack_state: got %b want %b", st, 7'b0); end
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_no_timeout();
    int seen_err = 0;
    int lost_gnt = 0;
    req0 = 1'b1; addr0 = 32'h0000_6000;
    tick();
    for (int c = 0; c < 300; c++) begin
      #2;
      if (n_err0 !== 1'b0) seen_err++;
      if (n_gnt0 !== 1'b1) lost_gnt++;
      tick();
    end
    n_vec++; if (seen_err !== 0) begin n_err++; $display("FAIL notimeout_err: got %0d err cycles want 0", seen_err); end
    n_vec++; if (lost_gnt !== 0) begin n_err++; $display("FAIL notimeout_gnt: got %0d cycles without grant want 0", lost_gnt); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
    #2;
    n_vec++; if (n_ack0 !== 1'b1 || n_rdata !== 32'h0000_ABCD) begin
      n_err++; $display("FAIL notimeout_ack: got %b/%h want 1/0000abcd", n_ack0, n_rdata);
    end
    tick();
    clear_inputs();
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_reset_mid();
    req1 = 1'b1; addr1 = 32'h0000_7000;
    tick();
    #2;
    n_vec++; if (st !== 7'b0110000) begin n_err++; $display("FAIL rstmid_busy1: got %b want %b", st, 7'b0110000); end
    tick();
    mem_ack = 1'b1;
    #2;
    n_vec++; if (st !== 7'b0110100) begin n_err++; $display("FAIL rstmid_pre_ack: got %b want %b", st, 7'b0110100); end
    rst = 1'b1;
    #1;
    n_vec++; if (st !== 7'b0 || mem_addr !== 32'd0) begin n_err++; $display("FAIL rstmid_drop: got %b/%h want 0/0", st, mem_addr); end
    tick();
    rst = 1'b0; req1 = 1'b0;
    #2;
    n_vec++; if (st !== 7'b0) begin n_err++; $display("FAIL rstmid_late_ack: got %b want %b", st, 7'b0); end
    tick();
    mem_ack = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    mem_ack = 1'b1;
    #2;
    n_vec++; if (st !== 7'b1011000) begin n_err++; $display("FAIL rstmid_regrant0: got %b want %b", st, 7'b1011000); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int owner = -1;
    int last = 1;
    int waited = 0;
    logic done0 = 1'b0;
    logic done1 = 1'b0;
    logic [6:0] exp;
    logic a_s, e_s;
    rst = 1'b1; clear_inputs();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done0) req0 = 1'b0;
      else if (!req0 && ($urandom % 3 == 0)) begin req0 = 1'b1; addr0 = $urandom; wdata0 = $urandom; we0 = 1'($urandom % 2); end
      if (done1) req1 = 1'b0;
      else if (!req1 && ($urandom % 3 == 0)) begin req1 = 1'b1; addr1 = $urandom; wdata1 = $urandom; we1 = 1'($urandom % 2); end
      done0 = 1'b0; done1 = 1'b0;
      mem_ack = ($urandom % 4 == 0); mem_rdata = $urandom;
      #2;
      a_s = (owner >= 0) && mem_ack;
      e_s = (owner >= 0) && !mem_ack && (waited + 1 == T_MAIN);
      exp = {(owner == 0), (owner == 1), (owner >= 0), a_s && owner == 0, a_s && owner == 1,
             e_s && owner == 0, e_s && owner == 1};
      n_vec++; if (st !== exp) begin n_err++; $display("FAIL rand_status c%0d: got %b want %b", c, st, exp); end
      if (owner >= 0) begin
        n_vec++; if (mem_addr !== (owner == 1 ? addr1 : addr0) || mem_wdata !== (owner == 1 ? wdata1 : wdata0)
                     || mem_we !== (owner == 1 ? we1 : we0)) begin
          n_err++; $display("FAIL rand_port c%0d: got %h/%h/%b owner %0d", c, mem_addr, mem_wdata, mem_we, owner);
        end
      end
      if (a_s) begin
        n_vec++; if (rdata !== mem_rdata) begin n_err++; $display("FAIL rand_rdata c%0d: got %h want %h", c, rdata, mem_rdata); end
      end
      if (owner >= 0) begin
        if (a_s || e_s) begin
          if (owner == 0) done0 = 1'b1; else done1 = 1'b1;
          owner = -1;
        end else begin
          waited++;
        end
      end else if (req0 || req1) begin
        owner  = (req0 && req1) ? 1 - last : (req0 ? 0 : 1);
        last   = owner;
        waited = 0;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_write_steering();
    test_contention();
    test_timeout();
    test_boundary();
    test_no_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
